// File: rtl/readout_sequencer_if.sv
// Handshake and chain bundle between readout_sequencer, the pixel column and the word consumer.
// Latency: none (signal bundle only).
// Backpressure: word_ready from the consumer stalls the serial chain through shift_en.
// Signals:
//   start/acq_len/summing_mode  frame request and its parameters
//   cnt_clr/shutter_a/shutter_b pixel column control
//   shift_en/ser_in_a/ser_in_b  serial chain strobe and tail bits
//   word_*                      deserialised word pair, valid/ready
//   busy/frame_done             frame status
// Modports: master = sequencer side, slave = column plus consumer side.
interface readout_sequencer_if #(
   parameter int CNT_W = 12,
   parameter int N_PIX = 16
);
   localparam int PIX_W = $clog2(N_PIX);

   logic             start;
   logic [15:0]      acq_len;
   logic             summing_mode;
   logic             cnt_clr;
   logic             shutter_a;
   logic             shutter_b;
   logic             shift_en;
   logic             ser_in_a;
   logic             ser_in_b;
   logic             word_valid;
   logic             word_ready;
   logic [CNT_W-1:0] word_a;
   logic [CNT_W-1:0] word_b;
   logic [PIX_W-1:0] word_pix;
   logic             busy;
   logic             frame_done;

   modport master (
      input  start, acq_len, summing_mode, ser_in_a, ser_in_b, word_ready,
      output cnt_clr, shutter_a, shutter_b, shift_en,
             word_valid, word_a, word_b, word_pix, busy, frame_done
   );

   modport slave (
      output start, acq_len, summing_mode, ser_in_a, ser_in_b, word_ready,
      input  cnt_clr, shutter_a, shutter_b, shift_en,
             word_valid, word_a, word_b, word_pix, busy, frame_done
   );
endinterface

// File: rtl/readout_sequencer.sv
// Frame controller for one pixel column: clear, shutter, settle, then deserialise A/B chains.
// Latency: word pair valid the cycle after its last bit shifts; frame_done on the final accept.
// Backpressure: a held word blocks only the last bit of the next word (shift_en drops there).
// Ports:
//   clk_read  single rising-edge clock
//   reset     synchronous active-low reset
//   bus       readout_sequencer_if.master (frame control, chain, word handshake, status)
module readout_sequencer #(
   parameter int CNT_W      = 12,
   parameter int N_PIX      = 16,
   parameter int CLR_CYC    = 2,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 clk_read,
   input  logic                 reset,
   readout_sequencer_if.master  bus
);
   localparam int PIX_W  = $clog2(N_PIX);
   localparam int PCNT_W = $clog2(N_PIX + 1);
   localparam int BIT_W  = $clog2(CNT_W);

   localparam logic [15:0]       CLR_LAST    = 16'(CLR_CYC - 1);
   localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(CNT_W - 1);
   localparam logic [PCNT_W-1:0] PIX_END     = PCNT_W'(N_PIX);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACQ,
      SETTLE,
      READ
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       cyc_q, cyc_d;
   logic [15:0]       acq_len_q, acq_len_d;
   logic              summing_q, summing_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CNT_W-2:0]  sh_a_q, sh_a_d;
   logic [CNT_W-2:0]  sh_b_q, sh_b_d;
   logic [CNT_W-1:0]  word_a_q, word_a_d;
   logic [CNT_W-1:0]  word_b_q, word_b_d;
   logic [PIX_W-1:0]  word_pix_q, word_pix_d;
   logic              word_valid_q, word_valid_d;
   logic              cnt_clr_q, cnt_clr_d;
   logic              shutter_a_q, shutter_a_d;
   logic              shutter_b_q, shutter_b_d;
   logic              shift;
   logic              accept;
   logic              done;

   always_comb begin
      state_d      = state_q;
      cyc_d        = cyc_q;
      acq_len_d    = acq_len_q;
      summing_d    = summing_q;
      bit_cnt_d    = bit_cnt_q;
      pix_cnt_d    = pix_cnt_q;
      sh_a_d       = sh_a_q;
      sh_b_d       = sh_b_q;
      word_a_d     = word_a_q;
      word_b_d     = word_b_q;
      word_pix_d   = word_pix_q;
      word_valid_d = word_valid_q;
      shift        = 1'b0;
      accept       = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acq_len_d = bus.acq_len;
               summing_d = bus.summing_mode;
               cyc_d     = '0;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            if (cyc_q == CLR_LAST) begin
               cyc_d   = '0;
               state_d = (acq_len_q == 16'd0) ? SETTLE : ACQ;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         ACQ: begin
            if (cyc_q == acq_len_q - 16'd1) begin
               cyc_d   = '0;
               state_d = SETTLE;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         SETTLE: begin
            if (cyc_q == SETTLE_LAST) begin
               cyc_d     = '0;
               bit_cnt_d = '0;
               pix_cnt_d = '0;
               state_d   = READ;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         READ: begin
            accept = word_valid_q & bus.word_ready;
            // Only the completing bit would overwrite the output registers, so that is
            // the one shift that has to wait for a held word to drain.
            shift  = (pix_cnt_q != PIX_END) &&
                     !((bit_cnt_q == BIT_LAST) && word_valid_q && !bus.word_ready);
            if (accept) begin
               word_valid_d = 1'b0;
            end
            if (shift) begin
               if (bit_cnt_q == BIT_LAST) begin
                  // Completion wins over a same-cycle accept: valid stays high.
                  word_a_d     = {sh_a_q, bus.ser_in_a};
                  word_b_d     = {sh_b_q, bus.ser_in_b};
                  word_pix_d   = pix_cnt_q[PIX_W-1:0];
                  word_valid_d = 1'b1;
                  bit_cnt_d    = '0;
                  pix_cnt_d    = pix_cnt_q + 1'b1;
               end else begin
                  sh_a_d    = {sh_a_q[CNT_W-3:0], bus.ser_in_a};
                  sh_b_d    = {sh_b_q[CNT_W-3:0], bus.ser_in_b};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            if (accept && (pix_cnt_q == PIX_END)) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Column controls are registered from the next state so they switch on state edges.
      cnt_clr_d   = (state_d == CLEAR);
      shutter_a_d = (state_d == ACQ);
      shutter_b_d = (state_d == ACQ) && summing_d;
   end

   always_ff @(posedge clk_read) begin
      if (!reset) begin
         state_q      <= IDLE;
         cyc_q        <= '0;
         acq_len_q    <= '0;
         summing_q    <= 1'b0;
         bit_cnt_q    <= '0;
         pix_cnt_q    <= '0;
         sh_a_q       <= '0;
         sh_b_q       <= '0;
         word_a_q     <= '0;
         word_b_q     <= '0;
         word_pix_q   <= '0;
         word_valid_q <= 1'b0;
         cnt_clr_q    <= 1'b0;
         shutter_a_q  <= 1'b0;
         shutter_b_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         acq_len_q    <= acq_len_d;
         summing_q    <= summing_d;
         bit_cnt_q    <= bit_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         sh_a_q       <= sh_a_d;
         sh_b_q       <= sh_b_d;
         word_a_q     <= word_a_d;
         word_b_q     <= word_b_d;
         word_pix_q   <= word_pix_d;
         word_valid_q <= word_valid_d;
         cnt_clr_q    <= cnt_clr_d;
         shutter_a_q  <= shutter_a_d;
         shutter_b_q  <= shutter_b_d;
      end
   end

   assign bus.cnt_clr    = cnt_clr_q;
   assign bus.shutter_a  = shutter_a_q;
   assign bus.shutter_b  = shutter_b_q;
   assign bus.shift_en   = shift;
   assign bus.word_valid = word_valid_q;
   assign bus.word_a     = word_a_q;
   assign bus.word_b     = word_b_q;
   assign bus.word_pix   = word_pix_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.frame_done = done;
endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: frame vectors from a table plus a mid-read reset sequence.
// Latency: observes outputs on the falling edge, drives inputs 1 time unit after the rising edge.
// Backpressure: word_ready is pulled low for a programmed number of cycles while word 3 is held.
module tb_readout_sequencer;
   localparam int CW  = 12;
   localparam int NP  = 16;
   localparam int TOT = CW * NP;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   readout_sequencer_if #(.CNT_W(CW), .N_PIX(NP)) bus();

   readout_sequencer #(.CNT_W(CW), .N_PIX(NP), .CLR_CYC(2), .SETTLE_CYC(4)) dut (
      .clk_read (clk),
      .reset    (rst_n),
      .bus      (bus.master)
   );

   int tests = 0;
   int failed = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Pixel chain model: pixel 0 sits at the tail and leaves first, each word MSB first.
   logic [CW-1:0] model_a [NP];
   logic [CW-1:0] model_b [NP];
   int            ptr;
   logic [3:0]    mp;
   logic [3:0]    mb;

   always @(posedge clk) begin
      if (!rst_n || bus.cnt_clr) ptr <= 0;
      else if (bus.shift_en)     ptr <= ptr + 1;
   end

   always_comb begin
      mp = 4'(ptr / CW);
      mb = 4'(CW - 1 - (ptr % CW));
   end
   assign bus.ser_in_a = (ptr < TOT) ? model_a[mp][mb] : 1'b0;
   assign bus.ser_in_b = (ptr < TOT) ? model_b[mp][mb] : 1'b0;

   typedef struct packed {
      logic [3:0]    pix;
      logic [CW-1:0] a;
      logic [CW-1:0] b;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int acq;
      bit sum;
      int stall_len;
      bit start_in_read;
      int e_sa;
      int e_sb;
      int e_stall;
      int e_drop;
      int e_run;
   } vec_t;
   vec_t vecs[6];

   task automatic run_vec(input int vi);
      vec_t v;
      int   cyc, nclr, nsa, nsb, nset, nsh, nstall, drop, run, maxrun;
      int   nacc, ndone, post, busy_post, left, budget;
      bit   started, sent, done_seen, held_vld;
      exp_t held, got, e;
      v = vecs[vi];
      sb.delete();
      for (int k = 0; k < NP; k++) begin
         model_a[k] = 12'(k * 3 + vi * 7);
         model_b[k] = 12'(12'hFFF - k - vi);
         e.pix = 4'(k);
         e.a   = model_a[k];
         e.b   = model_b[k];
         sb.push_back(e);
      end
      cyc = 0; nclr = 0; nsa = 0; nsb = 0; nset = 0; nsh = 0; nstall = 0; drop = -1;
      run = 0; maxrun = 0; nacc = 0; ndone = 0; post = 0; busy_post = 0; left = 0;
      started = 0; sent = 0; done_seen = 0; held_vld = 0; held = '0;
      budget = v.acq + 600;

      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.acq_len      = 16'(v.acq);
      bus.summing_mode = v.sum;
      bus.word_ready   = 1'b1;

      while (post < 4 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         got.pix = bus.word_pix;
         got.a   = bus.word_a;
         got.b   = bus.word_b;
         if (bus.cnt_clr)   nclr++;
         if (bus.shutter_a) nsa++;
         if (bus.shutter_b) nsb++;
         if (bus.busy && !bus.cnt_clr && !bus.shutter_a && !bus.shift_en && nsh == 0) nset++;
         if (bus.shift_en) begin
            nsh++;
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            if (nsh > 0 && nsh < TOT) begin
               nstall++;
               if (drop < 0) drop = nsh;
            end
            run = 0;
         end
         if (held_vld) chk($sformatf("v%0d hold", vi), {bus.word_valid, got}, {1'b1, held});
         held_vld = bus.word_valid && !bus.word_ready;
         held     = got;
         if (bus.word_valid && bus.word_ready) begin
            nacc++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk($sformatf("v%0d word%0d", vi, e.pix), got, e);
            end
         end
         if (bus.frame_done) begin
            ndone++;
            done_seen = 1;
            chk($sformatf("v%0d done_on_last", vi),
                {bus.word_valid, bus.word_ready, bus.word_pix}, {1'b1, 1'b1, 4'd15});
         end else if (done_seen) begin
            post++;
            if (bus.busy) busy_post++;
         end

         @(posedge clk); #1;
         bus.start = 1'b0;
         if (v.start_in_read && !sent && nsh == 100) begin
            bus.start = 1'b1;
            sent = 1;
         end
         if (v.stall_len > 0) begin
            if (!started) begin
               if (bus.word_valid && bus.word_pix == 4'd3) begin
                  started        = 1;
                  bus.word_ready = 1'b0;
                  left           = v.stall_len - 1;
               end
            end else if (!bus.word_ready) begin
               if (left == 0) bus.word_ready = 1'b1;
               else           left--;
            end
         end
      end
      bus.start      = 1'b0;
      bus.word_ready = 1'b1;

      chk($sformatf("v%0d completed", vi), post, 4);
      chk($sformatf("v%0d cnt_clr cycles", vi), nclr, 2);
      chk($sformatf("v%0d shutter_a cycles", vi), nsa, v.e_sa);
      chk($sformatf("v%0d shutter_b cycles", vi), nsb, v.e_sb);
      chk($sformatf("v%0d settle cycles", vi), nset, 4);
      chk($sformatf("v%0d shifts", vi), nsh, TOT);
      chk($sformatf("v%0d stalls", vi), nstall, v.e_stall);
      chk($sformatf("v%0d first stall at shift", vi), drop, v.e_drop);
      chk($sformatf("v%0d longest shift run", vi), maxrun, v.e_run);
      chk($sformatf("v%0d words accepted", vi), nacc, NP);
      chk($sformatf("v%0d frame_done pulses", vi), ndone, 1);
      chk($sformatf("v%0d scoreboard left", vi), sb.size(), 0);
      chk($sformatf("v%0d busy after done", vi), busy_post, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  found;

      //              acq     sum stall sir  sa     sb     stl drop run
      vecs[0] = '{5,      1, 0,  0,  5,     5,     0,  -1,  192};
      vecs[1] = '{7,      0, 0,  0,  7,     0,     0,  -1,  192};
      vecs[2] = '{0,      1, 0,  1,  0,     0,     0,  -1,  192};
      vecs[3] = '{3,      1, 16, 0,  3,     3,     5,  59,  133};
      vecs[4] = '{2,      0, 10, 0,  2,     0,     0,  -1,  192};
      vecs[5] = '{65535,  1, 0,  0,  65535, 65535, 0,  -1,  192};

      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.acq_len      = 16'd0;
      bus.summing_mode = 1'b0;
      bus.word_ready   = 1'b1;
      for (int k = 0; k < NP; k++) begin
         model_a[k] = '0;
         model_b[k] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", bus.busy, 0);
      chk("reset controls", {bus.cnt_clr, bus.shutter_a, bus.shutter_b, bus.shift_en}, 0);
      chk("reset word", {bus.word_valid, bus.frame_done, bus.word_pix, bus.word_a, bus.word_b}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(i);

      // Reset while pixel 7 is held at the output, then a clean frame.
      for (int k = 0; k < NP; k++) begin
         model_a[k] = 12'(k * 3);
         model_b[k] = 12'(12'hFFF - k);
      end
      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.acq_len      = 16'd1;
      bus.summing_mode = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      found = 0;
      n = 0;
      while (!found && n < 500) begin
         @(posedge clk); #1;
         n++;
         if (bus.word_valid && bus.word_pix == 4'd7) found = 1;
      end
      chk("reached pixel 7", found, 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midread reset busy", bus.busy, 0);
      chk("midread reset controls", {bus.cnt_clr, bus.shutter_a, bus.shutter_b, bus.shift_en}, 0);
      chk("midread reset word valid", bus.word_valid, 0);
      chk("midread reset word", {bus.frame_done, bus.word_pix, bus.word_a, bus.word_b}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_vec(0);

      run_vec(5);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
